traffic_countdown_display: RTL and testbench
============================================

// Module: traffic_countdown_display
// PURPOSE
//  Downstream consumer of the traffic-light FSM's 2-bit led code (00 red, 01 green, 10 yellow).
//  Tracks phase changes, counts down the seconds left in the current phase, and converts the count to BCD.
//  Drives a two-digit, time-multiplexed, active-low 7-segment display beside the signal head.
//  Runs on the same clk as the FSM; sec_tick marks each FSM advance.
// PARAMETERS
//  RED_SEC      18  seconds loaded on entry to red (max 99)
//  GREEN_SEC    15  seconds loaded on entry to green (max 99)
//  YELLOW_SEC   3   seconds loaded on entry to yellow (max 99)
//  REFRESH_DIV  4   clk cycles per digit slot in the 7-seg multiplex (>=2)
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  led        in   2  phase code from FSM: 00 red, 01 green, 10 yellow, 11 invalid
//  sec_tick   in   1  one-cycle pulse per elapsed second (tie 1 when clk is 1 Hz)
//  remaining  out  7  seconds left in the current phase, registered
//  bcd_tens   out  4  tens digit of remaining
//  bcd_ones   out  4  ones digit of remaining
//  seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//  an         out  2  digit enables, active-low; an[1] tens, an[0] ones
//  phase_err  out  1  high while led==11
// BEHAVIOUR
//  Reset: remaining=RED_SEC, led_q=00, phase_err=0, seg=7'h7F, an=2'b11, refresh cnt=0, digit sel=0.
//  led_q registers led every cycle. A phase change is (led != led_q).
//  Priority, highest first, evaluated per cycle:
//   1. led==11: remaining<=0, phase_err<=1.
//   2. Phase change to a valid code: remaining<=duration(led), phase_err<=0. Overrides a coincident sec_tick.
//   3. sec_tick with no change: remaining<=remaining-1 if remaining>1; else hold.
//      The count saturates at 1 and never wraps.
//   4. Otherwise hold.
//  Leaving 11 for a valid code counts as a phase change and loads that code's duration.
//  Latency: remaining, bcd_tens/ones and phase_err change 1 cycle after the causing input.
//  bcd_tens/ones are combinational from remaining: tens=remaining/10, ones=remaining%10, both 0..9.
//  Multiplex: refresh counter 0..REFRESH_DIV-1; the digit select toggles at wrap.
//   sel=0 drives the ones digit (an=2'b10); sel=1 drives the tens digit (an=2'b01).
//  seg and an are registered, 1 cycle after remaining/sel.
//   Standard hex-free decode, 0..9 only.
//  Tens leading-zero blanking: when bcd_tens==0, the tens slot gives an=2'b11 and seg=7'h7F.
//  phase_err=1: both slots show a dash (seg=7'b0111111, g segment only), each enabled in its slot.
//  Reset mid-operation: every register returns to its reset value immediately (async).
//   Counting resumes from RED_SEC after release.
// CONFIGURATION
//  COUNTDOWN_BLINK_EN defined:
//   - A blink register toggles on each sec_tick and clears on phase change or reset.
//   - While remaining<=3, phase_err=0 and blink=1, both digits are blanked (an=2'b11, seg=7'h7F).
//  COUNTDOWN_BLINK_EN undefined:
//   - No blink register exists; the digits are always shown per the rules above.
//   - remaining and bcd outputs are identical in both builds.
// TESTING
//  1. Reset, release, sec_tick=1 with led=00 held -> remaining steps 18,17..1, then holds at 1; bcd 1/8 after reset.
//  2. led 00->01 coincident with sec_tick -> remaining=15 next cycle (load wins); next tick gives 14.
//  3. Sequence red/green/yellow -> yellow loads 3; only the ones digit is lit (tens blanked); seg for 3 = 7'b0110000.
//  4. led=11 for 2 cycles, then 10 -> phase_err=1 and remaining=0 with dashes; then phase_err=0, remaining=3.
//  5. rst_n low mid-green (remaining=9) -> outputs go to reset values asynchronously; remaining=18 after release.
//  6. COUNTDOWN_BLINK_EN: yellow phase, remaining=3..1 -> display blanked on alternate ticks; without the macro, never blanked.

Source files
------------

// File: rtl/traffic_countdown_display.sv
// traffic_countdown_display: phase countdown with BCD split and 2-digit active-low 7-seg multiplex.
// Optional COUNTDOWN_BLINK_EN: blank the display on alternate seconds during the last 3 s of a phase.
`timescale 1ns/1ps
`default_nettype none

module traffic_countdown_display #(
  parameter int RED_SEC     = 18,
  parameter int GREEN_SEC   = 15,
  parameter int YELLOW_SEC  = 3,
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] led,
  input  logic       sec_tick,
  output logic [6:0] remaining,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       phase_err
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_OFF  = 7'h7F;
  localparam logic [6:0]    SEG_DASH = 7'b0111111;

  logic [1:0]    led_q;
  logic          change;
  logic [CW-1:0] refresh_cnt;
  logic          sel;
  logic [3:0]    digit;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;
  logic          blank;

  assign change = (led != led_q);

  function automatic logic [6:0] duration(input logic [1:0] code);
    case (code)
      2'b00:   duration = 7'(RED_SEC);
      2'b01:   duration = 7'(GREEN_SEC);
      default: duration = 7'(YELLOW_SEC);
    endcase
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Invalid code dominates; a fresh valid phase overrides a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= 2'b00;
      remaining <= 7'(RED_SEC);
      phase_err <= 1'b0;
    end else begin
      led_q <= led;
      if (led == 2'b11) begin
        remaining <= 7'd0;
        phase_err <= 1'b1;
      end else if (change) begin
        remaining <= duration(led);
        phase_err <= 1'b0;
      end else if (sec_tick && (remaining > 7'd1)) begin
        remaining <= remaining - 7'd1;
      end
    end
  end

  assign bcd_tens = 4'(remaining / 7'd10);
  assign bcd_ones = 4'(remaining % 7'd10);

`ifdef COUNTDOWN_BLINK_EN
  logic blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink <= 1'b0;
    end else if (change) begin
      blink <= 1'b0;
    end else if (sec_tick) begin
      blink <= ~blink;
    end
  end

  assign blank = blink && !phase_err && (remaining <= 7'd3);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      sel         <= 1'b0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      sel         <= ~sel;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  always_comb begin
    digit    = sel ? bcd_tens : bcd_ones;
    seg_next = SEG_OFF;
    an_next  = 2'b11;
    if (phase_err) begin
      seg_next = SEG_DASH;
      an_next  = sel ? 2'b01 : 2'b10;
    end else if (blank || (sel && (bcd_tens == 4'd0))) begin
      seg_next = SEG_OFF;
      an_next  = 2'b11;
    end else begin
      seg_next = seg7(digit);
      an_next  = sel ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= 2'b11;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_traffic_countdown_display.sv
// Scoreboard bench for traffic_countdown_display: stimulus queues expectations, a negedge monitor checks them.
`timescale 1ns/1ps
`default_nettype none

module tb_traffic_countdown_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] led = 2'b00;
  logic       sec_tick = 1'b0;
  logic [6:0] remaining;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [6:0] seg;
  logic [1:0] an;
  logic       phase_err;

  traffic_countdown_display dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led       (led),
    .sec_tick  (sec_tick),
    .remaining (remaining),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .seg       (seg),
    .an        (an),
    .phase_err (phase_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         sig;
    logic [8:0] v0;
    logic [8:0] v1;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

`ifdef COUNTDOWN_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Digit-slot timing: a slot lasts 4 cycles from reset; seg/an show the slot of the previous cycle.
  int   mcnt;
  logic msel, msel_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0; msel <= 1'b0; msel_d <= 1'b0;
    end else begin
      msel_d <= msel;
      if (mcnt == 3) begin mcnt <= 0; msel <= ~msel; end
      else mcnt <= mcnt + 1;
    end
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000;  1: pat = 7'b1111001;  2: pat = 7'b0100100;
      3: pat = 7'b0110000;  4: pat = 7'b0011001;  5: pat = 7'b0010010;
      6: pat = 7'b0000010;  7: pat = 7'b1111000;  8: pat = 7'b0000000;
      9: pat = 7'b0010000;  default: pat = 7'h7F;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      0: sig_name = "remaining";
      1: sig_name = "bcd_tens";
      2: sig_name = "bcd_ones";
      3: sig_name = "phase_err";
      default: sig_name = "display{an,seg}";
    endcase
  endfunction

  task automatic push(input int due, input int sig, input logic [8:0] v0, input logic [8:0] v1);
    exp_t e;
    e.due = due; e.sig = sig; e.v0 = v0; e.v1 = v1;
    sb.push_back(e);
  endtask

  task automatic exp_state(input int due, input int rem, input bit err);
    push(due, 0, 9'(rem), 9'(rem));
    push(due, 1, 9'(rem / 10), 9'(rem / 10));
    push(due, 2, 9'(rem % 10), 9'(rem % 10));
    push(due, 3, 9'(err), 9'(err));
  endtask

  // v0: expected {an,seg} in the ones slot, v1: in the tens slot.
  task automatic exp_disp(input int due, input int rem, input bit err, input bit blank);
    logic [8:0] s0, s1;
    if (err) begin
      s0 = {2'b10, 7'b0111111};
      s1 = {2'b01, 7'b0111111};
    end else if (blank) begin
      s0 = {2'b11, 7'h7F};
      s1 = {2'b11, 7'h7F};
    end else begin
      s0 = {2'b10, pat(rem % 10)};
      s1 = (rem / 10 == 0) ? {2'b11, 7'h7F} : {2'b01, pat(rem / 10)};
    end
    push(due, 4, s0, s1);
  endtask

  function automatic logic [8:0] actual(input int sig);
    case (sig)
      0: actual = {2'b00, remaining};
      1: actual = {5'b0, bcd_tens};
      2: actual = {5'b0, bcd_ones};
      3: actual = {8'b0, phase_err};
      default: actual = {an, seg};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [8:0] want, got;
        want = (sb[i].sig == 4 && msel_d) ? sb[i].v1 : sb[i].v0;
        got  = actual(sb[i].sig);
        n_total++;
        if (sb[i].due < cyc)
          $display("FAIL %s stale entry due %0d seen at cycle %0d", sig_name(sb[i].sig), sb[i].due, cyc);
        else if (got !== want)
          $display("FAIL %s at cycle %0d: got %h, expected %h", sig_name(sb[i].sig), cyc, got, want);
        else
          n_pass++;
        sb.delete(i);
      end
    end
  end

  task automatic drive(input logic [1:0] l, input logic t, output int now);
    @(posedge clk);
    #1;
    led = l;
    sec_tick = t;
    now = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      n_total++;
      $display("FAIL %s never checked (due %0d)", sig_name(sb[0].sig), sb[0].due);
      void'(sb.pop_front());
    end
  endtask

  typedef struct {
    logic [1:0] l;
    logic       t;
    int         rem;
    bit         bl;
  } vec_t;

  initial begin
    int   now;
    vec_t blink_vec[10];

    // reset state
    @(posedge clk); #1;
    exp_state(cyc, 18, 1'b0);
    exp_disp(cyc, 18, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // red countdown to saturation
    for (int k = 1; k <= 20; k++) begin
      drive(2'b00, 1'b1, now);
      exp_state(now + 1, (18 - k > 1) ? 18 - k : 1, 1'b0);
    end

    // green load wins over coincident tick, then counts
    drive(2'b01, 1'b1, now);
    exp_state(now + 1, 15, 1'b0);
    exp_disp(now + 2, 15, 1'b0, 1'b0);
    drive(2'b01, 1'b1, now);
    exp_state(now + 1, 14, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(2'b01, 1'b0, now);
      exp_state(now + 1, 14, 1'b0);
      exp_disp(now + 2, 14, 1'b0, 1'b0);
    end

    // yellow: tens blanked, ones shows 3
    for (int k = 0; k < 8; k++) begin
      drive(2'b10, 1'b0, now);
      exp_state(now + 1, 3, 1'b0);
      exp_disp(now + 2, 3, 1'b0, 1'b0);
    end

    // invalid code then recovery to yellow
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 1'b0, now);
      exp_state(now + 1, 0, 1'b1);
      exp_disp(now + 2, 0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      drive(2'b10, 1'b0, now);
      exp_state(now + 1, 3, 1'b0);
      exp_disp(now + 2, 3, 1'b0, 1'b0);
    end

    // green down to 9, then asynchronous reset
    drive(2'b01, 1'b0, now);
    exp_state(now + 1, 15, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      drive(2'b01, 1'b1, now);
      exp_state(now + 1, 15 - k, 1'b0);
    end
    drive(2'b01, 1'b0, now);
    exp_disp(now + 2, 9, 1'b0, 1'b0);
    drain();
    @(posedge clk); #3;
    rst_n = 1'b0; led = 2'b00; sec_tick = 1'b0;
    exp_state(cyc, 18, 1'b0);
    exp_disp(cyc, 18, 1'b0, 1'b1);
    @(posedge clk); #1;
    exp_state(cyc, 18, 1'b0);
    rst_n = 1'b1;
    drive(2'b00, 1'b0, now);
    exp_state(now + 1, 18, 1'b0);
    drive(2'b00, 1'b1, now);
    exp_state(now + 1, 17, 1'b0);

    // yellow last seconds: blanking on alternate ticks only when blinking is built in
    blink_vec = '{'{2'b10, 1'b0, 3, 1'b0}, '{2'b10, 1'b0, 3, 1'b0}, '{2'b10, 1'b1, 2, 1'b1},
                  '{2'b10, 1'b0, 2, 1'b1}, '{2'b10, 1'b0, 2, 1'b1}, '{2'b10, 1'b1, 1, 1'b0},
                  '{2'b10, 1'b0, 1, 1'b0}, '{2'b10, 1'b1, 1, 1'b1}, '{2'b10, 1'b0, 1, 1'b1},
                  '{2'b10, 1'b1, 1, 1'b0}};
    foreach (blink_vec[i]) begin
      drive(blink_vec[i].l, blink_vec[i].t, now);
      exp_state(now + 1, blink_vec[i].rem, 1'b0);
      exp_disp(now + 2, blink_vec[i].rem, 1'b0, BLINK_BUILD && blink_vec[i].bl);
    end
    drive(2'b10, 1'b0, now);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
